sd_seq_gen: RTL and testbench
=============================

Name: sd_seq_gen

Overview:
Srdy/drdy producer-side traffic generator for block-level benches. It drives an incrementing data sequence with a programmable srdy gap pattern, optional word-count limit and single-word error injection. It is the source end of a DUT whose output feeds a sequence checker. It is synthesizable-style RTL with a run/done handshake to the bench.

Parameters:
width, 8, data width of p_data and cfg_init
pat_dep, 8, length in bits of the srdy gap pattern
cnt_width, 16, width of cfg_count and sent_cnt

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_start  input  1  single-cycle pulse; latches config and starts a run
cfg_init  input  width  first data value of the run
cfg_count  input  cnt_width  words to send; 0 = unlimited
cfg_srdy_pat  input  pat_dep  srdy pattern; bit i=1 allows srdy in slot i
cfg_err_inj  input  1  pulse; corrupts the next word offered after the pulse
p_srdy  output  1  producer data valid
p_drdy  input  1  consumer ready
p_data  output  width  producer data
done  output  1  high after the last word of a limited run is accepted
busy  output  1  high while state is RUN
sent_cnt  output  cnt_width  words accepted in the current run; wraps

Behaviour:
- Reset: p_srdy=0, p_data=0, done=0, busy=0, sent_cnt=0, state=IDLE, pattern pointer dpp=0, pending error flag=0. Reset mid-run aborts immediately; no word is completed.
- Transfer: p_srdy & p_drdy on a rising clk edge.
- Protocol: once p_srdy=1, p_srdy and p_data are held until the transfer occurs. Neither may change while p_srdy=1 and p_drdy=0.
- States:
  - IDLE: cfg_start -> RUN.
  - RUN: the last word of a limited run is transferred -> DONE.
  - DONE: cfg_start -> RUN.
  - cfg_start while in RUN is ignored.
- On start:
  - Latch cfg_count, cfg_srdy_pat and cfg_init.
  - seq <= cfg_init; sent_cnt <= 0; done <= 0.
  - p_srdy <= pat[0]; dpp <= 1 mod pat_dep.
  - If pat[0]=1, the first word (cfg_init) is visible the cycle after cfg_start.
- All-zero pattern is treated as all-ones (guarantees progress).
- Slot advance: in RUN, on each cycle where p_srdy=0 or a transfer occurs:
  - next p_srdy = pat[dpp] AND (remaining words after this cycle > 0, or count=0).
  - dpp <= (dpp+1) mod pat_dep.
  - Stalled cycles (p_srdy=1, p_drdy=0) do not advance dpp.
- Data:
  - p_data = seq when offered.
  - After each transfer, seq <= seq+1, modulo 2^width (0xFF wraps to 0x00 at width=8).
  - p_data is registered and updated only when a new word is presented.
- sent_cnt increments per transfer, modulo 2^cnt_width.
- Limited run: after transfer number cfg_count, p_srdy <= 0, state <= DONE, done <= 1, busy <= 0. done holds until the next cfg_start or reset.
- Unlimited run (count=0): never leaves RUN except by reset.
- Error injection:
  - cfg_err_inj sets the pending flag.
  - The next word presented (p_srdy rising, or the word following a transfer) goes out with bit 0 inverted, and the flag clears.
  - seq is not disturbed, so the following word is correct.
  - A pulse arriving while a word is held stalled affects the next word, not the held one.
  - Pulses while the flag is already set are absorbed.
  - The flag is cleared by reset and by cfg_start.
- Simultaneous cfg_start and cfg_err_inj: the start clears the flag, then the flag is set, so the first word of the run is corrupted.

Test Plan:
- pat=8'hFF, init=8'h00, count=10, drdy tied 1 -> words 0x00..0x09 on 10 consecutive cycles; done=1 the cycle after word 0x09; sent_cnt=10.
- pat=8'b01010101, count=4, drdy=1 -> srdy alternates 1/0; words 0x00..0x03 in cycles 1,3,5,7 after start.
- init=8'hFE, count=4, pat all-ones, drdy random -> sequence FE,FF,00,01; p_data stable during every stall; done after 01.
- err_inj pulse after word 0x02 accepted, count=5 -> bench sees 00,01,02,02,04: the fourth word is 0x03 with bit 0 inverted, and 0x04 follows uncorrupted.
- Reset asserted mid-run with srdy=1 and drdy=0 -> next cycle p_srdy=0, busy=0, sent_cnt=0; a fresh cfg_start restarts from cfg_init.
- cfg_start in RUN is ignored; pat=8'h00 behaves as 8'hFF; count=0 runs past 0xFFFF words with sent_cnt wrapping and done staying 0.

Source files
------------

// File: rtl/sd_seq_gen.sv
// sd_seq_gen: srdy/drdy source producing an incrementing word stream
// with a programmable srdy gap pattern, word limit and error injection.
module sd_seq_gen #(
  parameter int width     = 8,
  parameter int pat_dep   = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [width-1:0]     cfg_init,
  input  logic [cnt_width-1:0] cfg_count,
  input  logic [pat_dep-1:0]   cfg_srdy_pat,
  input  logic                 cfg_err_inj,
  output logic                 p_srdy,
  input  logic                 p_drdy,
  output logic [width-1:0]     p_data,
  output logic                 done,
  output logic                 busy,
  output logic [cnt_width-1:0] sent_cnt
);

  localparam int DW = (pat_dep > 1) ? $clog2(pat_dep) : 1;
  localparam logic [DW-1:0] DPP_ONE =
    (pat_dep > 1) ? DW'(1) : DW'(0);
  localparam logic [DW-1:0] DPP_MAX = DW'(pat_dep - 1);
  localparam logic [width-1:0] D_ONE = width'(1);
  localparam logic [cnt_width-1:0] C_ONE = cnt_width'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [width-1:0]      r_seq;
  logic [width-1:0]      r_data;
  logic [cnt_width-1:0]  r_cnt;
  logic [cnt_width-1:0]  r_sent;
  logic [pat_dep-1:0]    r_pat;
  logic [DW-1:0]         r_dpp;
  logic                  r_err;
  logic                  r_srdy;
  logic                  r_done;
  logic                  r_busy;

  logic [pat_dep-1:0]    w_pat_in;
  logic                  w_xfer;
  logic                  w_adv;
  logic                  w_last;
  logic                  w_err_now;
  logic                  w_slot;
  logic [width-1:0]      w_seq_nx;
  logic [width-1:0]      w_flip;
  logic [width-1:0]      w_flip_st;
  logic [cnt_width-1:0]  w_sent_nx;
  logic [DW-1:0]         w_dpp_nx;

  // An all-zero pattern would never offer a word, so it means "every slot".
  assign w_pat_in  = (cfg_srdy_pat == '0) ? '1 : cfg_srdy_pat;
  assign w_xfer    = r_srdy & p_drdy;
  assign w_adv     = (r_state == S_RUN) & (~r_srdy | w_xfer);
  assign w_sent_nx = r_sent + C_ONE;
  assign w_last    = w_xfer & (r_cnt != '0) & (w_sent_nx == r_cnt);
  assign w_seq_nx  = w_xfer ? (r_seq + D_ONE) : r_seq;
  assign w_err_now = r_err | cfg_err_inj;
  assign w_flip    = w_err_now ? D_ONE : '0;
  assign w_flip_st = cfg_err_inj ? D_ONE : '0;
  assign w_slot    = r_pat[r_dpp];
  assign w_dpp_nx  = (r_dpp == DPP_MAX) ? '0 : (r_dpp + DPP_ONE);

  // Run-control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_seq   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_sent  <= '0;
      r_pat   <= '0;
      r_dpp   <= '0;
      r_err   <= 1'b0;
      r_srdy  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (cfg_err_inj) r_err <= 1'b1;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (cfg_start) begin
            r_state <= S_RUN;
            r_cnt   <= cfg_count;
            r_pat   <= w_pat_in;
            r_seq   <= cfg_init;
            r_sent  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_srdy  <= w_pat_in[0];
            r_dpp   <= DPP_ONE;
            // Start clears the flag first, so a same-cycle pulse
            // lands on the first word of the run.
            if (w_pat_in[0]) begin
              r_data <= cfg_init ^ w_flip_st;
              r_err  <= 1'b0;
            end else begin
              r_err  <= cfg_err_inj;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_seq  <= w_seq_nx;
            r_sent <= w_sent_nx;
          end
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_srdy  <= 1'b0;
          end else if (w_adv) begin
            r_srdy <= w_slot;
            r_dpp  <= w_dpp_nx;
            if (w_slot) begin
              r_data <= w_seq_nx ^ w_flip;
              r_err  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign p_srdy   = r_srdy;
  assign p_data   = r_data;
  assign done     = r_done;
  assign busy     = r_busy;
  assign sent_cnt = r_sent;

endmodule

// File: tb/tb_sd_seq_gen.sv
// tb_sd_seq_gen: scoreboard bench for sd_seq_gen; expected words are
// queued by the stimulus and popped by a monitor on each transfer.
module tb_sd_seq_gen;

  logic        clk;
  logic        reset;
  logic        cfg_start;
  logic [7:0]  cfg_init;
  logic [15:0] cfg_count;
  logic [7:0]  cfg_srdy_pat;
  logic        cfg_err_inj;
  logic        p_srdy;
  logic        p_drdy;
  logic [7:0]  p_data;
  logic        done;
  logic        busy;
  logic [15:0] sent_cnt;

  sd_seq_gen #(
    .width(8),
    .pat_dep(8),
    .cnt_width(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_start(cfg_start),
    .cfg_init(cfg_init),
    .cfg_count(cfg_count),
    .cfg_srdy_pat(cfg_srdy_pat),
    .cfg_err_inj(cfg_err_inj),
    .p_srdy(p_srdy),
    .p_drdy(p_drdy),
    .p_data(p_data),
    .done(done),
    .busy(busy),
    .sent_cnt(sent_cnt)
  );

  typedef struct {
    logic [7:0] d;
    int         e;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int edges = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Monitor: sampled on the falling edge; a transfer happens at the
  // next rising edge (numbered edges+1) when srdy & drdy and no reset.
  always @(negedge clk) begin
    exp_t x;
    if (prev_stall) begin
      total++;
      if (p_srdy !== 1'b1 || p_data !== prev_data) begin
        bad++;
        $display("FAIL hold srdy=%b data=%h want srdy=1 data=%h",
                 p_srdy, p_data, prev_data);
      end
    end
    if (!reset && p_srdy === 1'b1 && p_drdy === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL extra_word got=%h want=none", p_data);
      end else begin
        x = sbq.pop_front();
        if (p_data !== x.d) begin
          bad++;
          $display("FAIL word got=%h want=%h", p_data, x.d);
        end
        if (x.e >= 0) begin
          total++;
          if (edges + 1 != x.e) begin
            bad++;
            $display("FAIL word_edge got=%0d want=%0d", edges + 1, x.e);
          end
        end
      end
    end
    prev_stall = !reset && p_srdy === 1'b1 && p_drdy !== 1'b1;
    prev_data  = p_data;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic push(logic [7:0] d, int e);
    exp_t x;
    x.d = d;
    x.e = e;
    sbq.push_back(x);
  endtask

  // Issues a one-cycle start; s is the number of the edge that samples it.
  task automatic start(input logic [7:0] init, input logic [15:0] cnt,
                       input logic [7:0] pat, input logic err,
                       output int s);
    cfg_init     = init;
    cfg_count    = cnt;
    cfg_srdy_pat = pat;
    cfg_err_inj  = err;
    cfg_start    = 1'b1;
    s = edges + 1;
    tick();
    cfg_start   = 1'b0;
    cfg_err_inj = 1'b0;
  endtask

  initial begin
    int s;
    int n;
    logic [7:0] ri;
    logic [15:0] rc;
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_init = 8'h00;
    cfg_count = 16'd0;
    cfg_srdy_pat = 8'h00;
    cfg_err_inj = 1'b0;
    p_drdy = 1'b0;
    tick(2);
    chk("rst_srdy", p_srdy, 0);
    chk("rst_data", p_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", sent_cnt, 0);
    reset = 1'b0;
    tick();

    // Full pattern, 10 words back to back.
    p_drdy = 1'b1;
    start(8'h00, 16'd10, 8'hFF, 1'b0, s);
    for (int i = 0; i < 10; i++) push(8'(i), s + 1 + i);
    chk("t1_busy", busy, 1);
    chk("t1_first", p_data, 8'h00);
    tick(9);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_srdy_end", p_srdy, 0);
    chk("t1_cnt", sent_cnt, 10);

    // Alternating pattern: transfers on every second edge.
    start(8'h00, 16'd4, 8'b01010101, 1'b0, s);
    for (int i = 0; i < 4; i++) push(8'(i), s + 1 + 2 * i);
    tick(8);
    chk("t2_done", done, 1);
    chk("t2_cnt", sent_cnt, 4);

    // Data wrap with random drdy and an ignored mid-run start.
    start(8'hFE, 16'd4, 8'hFF, 1'b0, s);
    push(8'hFE, -1);
    push(8'hFF, -1);
    push(8'h00, -1);
    push(8'h01, -1);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      p_drdy = 1'($urandom_range(0, 1));
      cfg_start = (n == 0);
      cfg_init = 8'h55;
      tick();
      n++;
    end
    cfg_start = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_cnt", sent_cnt, 4);
    chk("t3_q", sbq.size(), 0);

    // Error pulse sampled while word 0x02 is on the bus.
    p_drdy = 1'b1;
    start(8'h00, 16'd5, 8'hFF, 1'b0, s);
    push(8'h00, s + 1);
    push(8'h01, s + 2);
    push(8'h02, s + 3);
    push(8'h02, s + 4);
    push(8'h04, s + 5);
    tick(2);
    cfg_err_inj = 1'b1;
    tick();
    cfg_err_inj = 1'b0;
    tick(3);
    chk("t4_done", done, 1);

    // Pulses during a stall hit the next word; a second pulse is absorbed.
    p_drdy = 1'b0;
    start(8'h10, 16'd3, 8'hFF, 1'b0, s);
    push(8'h10, s + 3);
    push(8'h10, s + 4);
    push(8'h12, s + 5);
    cfg_err_inj = 1'b1;
    tick(2);
    cfg_err_inj = 1'b0;
    p_drdy = 1'b1;
    tick(3);
    chk("t5_done", done, 1);

    // Start and error pulse together corrupt the first word.
    start(8'h20, 16'd2, 8'hFF, 1'b1, s);
    push(8'h21, s + 1);
    push(8'h21, s + 2);
    tick(2);
    chk("t6_done", done, 1);

    // Reset during a stalled offer aborts the run.
    p_drdy = 1'b0;
    start(8'h30, 16'd5, 8'hFF, 1'b0, s);
    tick(2);
    chk("t7_held", p_srdy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_srdy", p_srdy, 0);
    chk("t7_busy", busy, 0);
    chk("t7_cnt", sent_cnt, 0);
    p_drdy = 1'b1;
    start(8'h40, 16'd3, 8'hFF, 1'b0, s);
    for (int i = 0; i < 3; i++) push(8'(8'h40 + i), s + 1 + i);
    tick(3);
    chk("t7_done", done, 1);

    // Randomized limited runs against the word-sequence model.
    for (int r = 0; r < 12; r++) begin
      ri = 8'($urandom);
      rc = 16'($urandom_range(1, 20));
      start(ri, rc, 8'($urandom), 1'b0, s);
      for (int i = 0; i < rc; i++) push(8'(ri + 8'(i)), -1);
      n = 0;
      while (done !== 1'b1 && n < 2000) begin
        p_drdy = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      chk("rand_done", done, 1);
      chk("rand_cnt", sent_cnt, rc);
    end
    chk("rand_q", sbq.size(), 0);

    // Zero pattern acts as full; unlimited run wraps sent_cnt.
    p_drdy = 1'b1;
    ri = 8'($urandom);
    start(ri, 16'd0, 8'h00, 1'b0, s);
    for (int i = 0; i < 65540; i++) push(8'(ri + 8'(i)), s + 1 + i);
    tick(65540);
    reset = 1'b1;
    chk("t8_cnt", sent_cnt, 16'd4);
    chk("t8_done", done, 0);
    chk("t8_busy", busy, 1);
    tick();
    reset = 1'b0;
    tick(2);
    chk("final_q", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
